// File: rtl/fp_convert_arbiter_if.sv
// fp_convert_arbiter_if: requester bus (req/req_data/ack/result/result_id/busy) plus converter link (cv_d out, cv_s/cv_e/cv_f in)
interface fp_convert_arbiter_if #(parameter int NREQ = 4);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [12*NREQ-1:0] req_data;
  logic [NREQ-1:0] ack;
  logic [7:0] result;
  logic [IDW-1:0] result_id;
  logic busy;
  logic [11:0] cv_d;
  logic cv_s;
  logic [2:0] cv_e;
  logic [3:0] cv_f;
  modport master (output req, req_data, cv_s, cv_e, cv_f, input ack, result, result_id, busy, cv_d);
  modport slave (input req, req_data, cv_s, cv_e, cv_f, output ack, result, result_id, busy, cv_d);
endinterface

// File: rtl/fp_convert_arbiter.sv
// fp_convert_arbiter: round-robin share of one fpconverter; clk/rst plus bus (req,req_data in; ack,result,result_id,busy,cv_d out; cv_s,cv_e,cv_f in)
module fp_convert_arbiter #(
  parameter int NREQ = 4,
  parameter int CONV_LAT = 1
) (
  input logic clk,
  input logic rst,
  fp_convert_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW = CONV_LAT > 1 ? $clog2(CONV_LAT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [IDW-1:0] ptr, gid, win, rid;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] ack;
  logic [7:0] result;
  logic [11:0] cv_d;
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[(int'(ptr) + k) % NREQ]) win = IDW'((int'(ptr) + k) % NREQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack <= '0;
      result <= '0;
      rid <= '0;
      cv_d <= '0;
      ptr <= '0;
      gid <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          cv_d <= bus.req_data[12*win +: 12];
          gid <= win;
          cnt <= CW'(CONV_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          result <= {bus.cv_s, bus.cv_e, bus.cv_f};
          rid <= gid;
          ack <= NREQ'(1) << gid;
          ptr <= gid == IDW'(NREQ - 1) ? '0 : gid + 1'b1;
          state <= DONE;
        end
        DONE: begin
          ack <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ack = ack;
  assign bus.result = result;
  assign bus.result_id = rid;
  assign bus.cv_d = cv_d;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_fp_convert_arbiter.sv
// tb_fp_convert_arbiter: directed bench for fp_convert_arbiter with behavioural converters (CONV_LAT 1 and 3)
module tb_fp_convert_arbiter;
  logic clk = 0;
  logic rst = 1;
  int n_checks = 0;
  int n_fail = 0;
  int n;
  logic seen;
  logic [7:0] exp4 [4] = '{8'h01, 8'h3C, 8'h98, 8'h7F};
  always #5 clk = ~clk;
  fp_convert_arbiter_if #(.NREQ(4)) if1 ();
  fp_convert_arbiter_if #(.NREQ(4)) if2 ();
  fp_convert_arbiter #(.NREQ(4), .CONV_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  fp_convert_arbiter #(.NREQ(4), .CONV_LAT(3)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  function automatic logic [7:0] conv(input logic [11:0] d);
    logic [11:0] m;
    int e;
    logic [4:0] f;
    m = d[11] ? (d == 12'h800 ? 12'h7ff : -d) : d;
    e = 0;
    for (int i = 4; i <= 11; i++) if (m[i]) e = i - 3;
    if (e == 0) return {d[11], 3'd0, m[3:0]};
    f = 5'((m >> e) & 12'hf) + 5'(m[e-1]);
    if (f[4]) begin
      f = 5'd8;
      e++;
    end
    if (e > 7) return {d[11], 7'h7f};
    return {d[11], 3'(e), f[3:0]};
  endfunction
  assign {if1.cv_s, if1.cv_e, if1.cv_f} = conv(if1.cv_d);
  assign {if2.cv_s, if2.cv_e, if2.cv_f} = conv(if2.cv_d);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack1(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(|if1.ack) && cycles < 20);
  endtask
  initial begin
    if1.req = '0;
    if1.req_data = '0;
    if2.req = '0;
    if2.req_data = '0;
    tick();
    tick();
    rst = 0;
    check("rst_ack", 32'(if1.ack), 0);
    check("rst_result", 32'(if1.result), 0);
    check("rst_id", 32'(if1.result_id), 0);
    check("rst_cvd", 32'(if1.cv_d), 0);
    check("rst_busy", 32'(if1.busy), 0);
    check("rst_busy2", 32'(if2.busy), 0);
    if1.req_data[11:0] = 12'h200;
    if1.req = 4'b0001;
    tick();
    check("s_busy1", 32'(if1.busy), 1);
    check("s_ack1", 32'(if1.ack), 0);
    check("s_cvd", 32'(if1.cv_d), 32'h200);
    tick();
    check("s_ack2", 32'(if1.ack), 32'h1);
    check("s_busy2", 32'(if1.busy), 1);
    check("s_result", 32'(if1.result), 32'h68);
    check("s_id", 32'(if1.result_id), 0);
    if1.req = '0;
    tick();
    check("s_idle", 32'(if1.busy), 0);
    check("s_ack_low", 32'(if1.ack), 0);
    check("s_hold", 32'(if1.result), 32'h68);
    check("s_cvd_hold", 32'(if1.cv_d), 32'h200);
    if1.req_data[35:24] = 12'hA00;
    if1.req = 4'b0100;
    wait_ack1(n);
    check("neg_lat", 32'(n), 2);
    check("neg_ack", 32'(if1.ack), 32'h4);
    check("neg_result", 32'(if1.result), 32'hFC);
    check("neg_id", 32'(if1.result_id), 2);
    if1.req = '0;
    tick();
    if1.req_data[47:36] = 12'h123;
    if1.req = 4'b1000;
    tick();
    check("abort_busy", 32'(if1.busy), 1);
    check("abort_cvd", 32'(if1.cv_d), 32'h123);
    rst = 1;
    tick();
    rst = 0;
    if1.req = '0;
    check("abort_ack", 32'(if1.ack), 0);
    check("abort_result", 32'(if1.result), 0);
    check("abort_id", 32'(if1.result_id), 0);
    check("abort_cvd0", 32'(if1.cv_d), 0);
    check("abort_busy0", 32'(if1.busy), 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | (|if1.ack);
    end
    check("abort_no_ack", 32'(seen), 0);
    for (int r = 0; r < 2; r++) begin
      if1.req_data = {12'h7FF, 12'hFF0, 12'd96, 12'd1};
      if1.req = 4'hF;
      for (int i = 0; i < 4; i++) begin
        wait_ack1(n);
        check($sformatf("rr%0d_gap%0d", r, i), 32'(n), i == 0 ? 2 : 3);
        check($sformatf("rr%0d_ack%0d", r, i), 32'(if1.ack), 32'(1) << i);
        check($sformatf("rr%0d_res%0d", r, i), 32'(if1.result), 32'(exp4[i]));
        check($sformatf("rr%0d_id%0d", r, i), 32'(if1.result_id), 32'(i));
        if1.req[i] = 1'b0;
      end
      tick();
    end
    if1.req_data[23:12] = 12'd48;
    if1.req = 4'b0010;
    tick();
    if1.req_data[47:36] = 12'h800;
    if1.req[3] = 1'b1;
    wait_ack1(n);
    check("fair_ack_a", 32'(if1.ack), 32'h2);
    check("fair_res_a", 32'(if1.result), 32'h2C);
    wait_ack1(n);
    check("fair_ack_b", 32'(if1.ack), 32'h8);
    check("fair_gap_b", 32'(n), 3);
    check("fair_res_b", 32'(if1.result), 32'hFF);
    check("fair_id_b", 32'(if1.result_id), 3);
    if1.req[3] = 1'b0;
    wait_ack1(n);
    check("fair_ack_c", 32'(if1.ack), 32'h2);
    check("fair_id_c", 32'(if1.result_id), 1);
    if1.req = '0;
    if2.req_data[11:0] = 12'd256;
    if2.req = 4'b0001;
    tick();
    check("lat3_busy", 32'(if2.busy), 1);
    check("lat3_cvd", 32'(if2.cv_d), 32'd256);
    if2.req_data[11:0] = 12'h7FF;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      seen = seen | (|if2.ack);
    end
    check("lat3_early", 32'(seen), 0);
    tick();
    check("lat3_ack", 32'(if2.ack), 32'h1);
    check("lat3_result", 32'(if2.result), 32'h58);
    check("lat3_id", 32'(if2.result_id), 0);
    if2.req = '0;
    tick();
    if2.req_data[23:12] = 12'h000;
    if2.req = 4'b0010;
    for (int i = 0; i < 4; i++) tick();
    check("zero_ack", 32'(if2.ack), 32'h2);
    check("zero_result", 32'(if2.result), 0);
    check("zero_id", 32'(if2.result_id), 1);
    if2.req = '0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
